// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the fifo block
package fifo_pkg;

  localparam int D_WIDTH   = 16;
  localparam int MIN_DEPTH = 2;

  function automatic int ptr_width(input int size);
    return $clog2(size);
  endfunction

  function automatic bit depth_ok(input int size);
    return (size >= MIN_DEPTH) && ((size & (size - 1)) == 0);
  endfunction

endpackage

// File: rtl/mod_N_counter.sv
// rtl/mod_N_counter.sv - modulo-N enable counter, used as a fifo pointer
module mod_N_counter #(
  parameter int N      = 4,
  parameter int N_BITS = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  output logic [N_BITS-1:0] count_o,
  output logic              done_o
);

  logic [N_BITS-1:0] count_q, count_d;
  logic              at_top;

  assign at_top = (count_q == N_BITS'(N - 1));

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = at_top ? '0 : count_q + N_BITS'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign done_o  = en_i && at_top;

endmodule

// File: rtl/fifo.sv
// rtl/fifo.sv - single-clock first-word-fall-through fifo; FIFO_LEVEL_EN adds a level output
module fifo
  import fifo_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH  = D_WIDTH,
  parameter int FIFO_BUFFER_SIZE = 1024
) (
  input  logic                               wr_clk,
  input  logic                               rd_clk,
  input  logic                               reset,
  input  logic                               wr_en,
  input  logic [FIFO_DATA_WIDTH-1:0]         din,
  input  logic                               rd_en,
  output logic [FIFO_DATA_WIDTH-1:0]         dout,
  output logic                               full,
  output logic                               empty
`ifdef FIFO_LEVEL_EN
  ,
  output logic [$clog2(FIFO_BUFFER_SIZE):0]  level
`endif
);

  localparam int PW = ptr_width(FIFO_BUFFER_SIZE);

  generate
    if (!depth_ok(FIFO_BUFFER_SIZE)) begin : g_bad_depth
      $error("fifo: FIFO_BUFFER_SIZE must be a power of two and at least 2");
    end
  endgenerate

  logic [FIFO_DATA_WIDTH-1:0] mem [0:FIFO_BUFFER_SIZE-1];
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [PW:0]                count_q, count_d;
  logic                       wr_ok, rd_ok;
  logic                       wr_done, rd_done;

  assign full  = (count_q == (PW + 1)'(FIFO_BUFFER_SIZE));
  assign empty = (count_q == '0);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  mod_N_counter #(.N(FIFO_BUFFER_SIZE), .N_BITS(PW)) u_wr_ptr (
    .clk_i   (wr_clk),
    .reset_i (reset),
    .en_i    (wr_ok),
    .count_o (wr_ptr),
    .done_o  (wr_done)
  );

  mod_N_counter #(.N(FIFO_BUFFER_SIZE), .N_BITS(PW)) u_rd_ptr (
    .clk_i   (wr_clk),
    .reset_i (reset),
    .en_i    (rd_ok),
    .count_o (rd_ptr),
    .done_o  (rd_done)
  );

  always_comb begin
    count_d = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + (PW + 1)'(1);
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - (PW + 1)'(1);
    end
  end

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage is deliberately not reset; the write during a reset cycle is harmless since wr_ptr returns to 0.
  always_ff @(posedge wr_clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  assign dout = empty ? '0 : mem[rd_ptr];

`ifdef FIFO_LEVEL_EN
  assign level = count_q;
`endif

  logic unused_sig;
  assign unused_sig = &{1'b0, rd_clk, wr_done, rd_done};

endmodule

// File: tb/tb_fifo.sv
// tb/tb_fifo.sv - self-checking bench for fifo against a queue model
module tb_fifo;

  localparam int W    = 16;
  localparam int SIZE = 1024;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;
  logic         full, empty;
`ifdef FIFO_LEVEL_EN
  logic [$clog2(SIZE):0] level;
`endif

  always #5 clk = ~clk;

  fifo #(.FIFO_DATA_WIDTH(W), .FIFO_BUFFER_SIZE(SIZE)) dut (
    .wr_clk (clk),
    .rd_clk (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .din    (din),
    .rd_en  (rd_en),
    .dout   (dout),
    .full   (full),
    .empty  (empty)
`ifdef FIFO_LEVEL_EN
    ,
    .level  (level)
`endif
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  bit           check_en = 1'b0;
  logic [W-1:0] model_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: a bounded queue with accept-if-room / pop-if-nonempty rules.
  always @(posedge clk) begin
    if (reset) begin
      model_q.delete();
    end else begin
      bit do_w, do_r;
      do_w = wr_en && (model_q.size() < SIZE);
      do_r = rd_en && (model_q.size() > 0);
      if (do_r) void'(model_q.pop_front());
      if (do_w) model_q.push_back(din);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("empty", 32'(empty), 32'(model_q.size() == 0));
      check("full", 32'(full), 32'(model_q.size() == SIZE));
      check("dout", 32'(dout), (model_q.size() > 0) ? 32'(model_q[0]) : 32'd0);
`ifdef FIFO_LEVEL_EN
      check("level", 32'(level), 32'(model_q.size()));
`endif
    end
  end

  // Drive one cycle of inputs from a negedge; return at the following negedge.
  task automatic cyc(input bit w, input logic [W-1:0] d, input bit r);
    wr_en = w;
    din   = d;
    rd_en = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] got[$];
    int           guard;

    @(negedge clk);
    cyc(0, '0, 0);
    cyc(0, '0, 0);
    reset = 1'b0;
    check_en = 1'b1;

    // idle after reset
    for (int i = 0; i < 10; i++) cyc(0, '0, 0);
    check("idle_empty", 32'(empty), 32'd1);
    check("idle_full", 32'(full), 32'd0);
    check("idle_dout", 32'(dout), 32'd0);

    // three writes, read back with rd_en = !empty
    cyc(1, 16'h0011, 0);
    check("fwft_dout", 32'(dout), 32'h0011);
    check("fwft_empty", 32'(empty), 32'd0);
    cyc(1, 16'h0022, 0);
    cyc(1, 16'h0033, 0);
    got.delete();
    guard = 0;
    while (!empty && guard < 10) begin
      got.push_back(dout);
      cyc(0, '0, 1);
      guard++;
    end
    check("seq_count", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      check("seq0", 32'(got[0]), 32'h0011);
      check("seq1", 32'(got[1]), 32'h0022);
      check("seq2", 32'(got[2]), 32'h0033);
    end
    check("seq_empty", 32'(empty), 32'd1);
    cyc(0, '0, 0);

    // fill to capacity, overflow write ignored, drain in order
    for (int i = 0; i < SIZE; i++) begin
      check("fill_not_full", 32'(full), 32'd0);
      cyc(1, W'(i), 0);
    end
    check("fill_full", 32'(full), 32'd1);
    cyc(1, 16'hBEEF, 0);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_head", 32'(dout), 32'd0);
    for (int i = 0; i < SIZE; i++) begin
      check("drain_val", 32'(dout), 32'(i));
      cyc(0, '0, 1);
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_dout", 32'(dout), 32'd0);

    // steady state at occupancy 5 with simultaneous read and write
    for (int i = 0; i < 5; i++) cyc(1, W'(16'h0100 + i), 0);
    for (int i = 0; i < 100; i++) cyc(1, W'(16'h0200 + i), 1);
    for (int i = 0; i < 5; i++) begin
      check("steady_tail", 32'(dout), 32'(16'h0200 + 95 + i));
      cyc(0, '0, 1);
    end
    check("steady_empty", 32'(empty), 32'd1);

    // full with simultaneous write and read: only the read happens
    for (int i = 0; i < SIZE; i++) cyc(1, W'(i) ^ 16'h5A5A, 0);
    check("full2", 32'(full), 32'd1);
    cyc(1, 16'hBEEF, 1);
    check("fullrw_full", 32'(full), 32'd0);
    check("fullrw_head", 32'(dout), 32'(16'h0001 ^ 16'h5A5A));
    guard = 0;
    while (!empty && guard < SIZE + 10) begin
      cyc(0, '0, 1);
      guard++;
    end
    check("fullrw_drain_count", 32'(guard), 32'(SIZE - 1));

    // empty with simultaneous write and read: only the write happens
    cyc(1, 16'h1234, 1);
    check("emptyrw_empty", 32'(empty), 32'd0);
    check("emptyrw_dout", 32'(dout), 32'h1234);
    cyc(0, '0, 1);
    check("emptyrw_pop", 32'(empty), 32'd1);

    // reset mid-stream discards contents and the pending transfer
    for (int i = 0; i < 4; i++) cyc(1, W'(16'h0A00 + i), 0);
    reset = 1'b1;
    cyc(1, 16'hDEAD, 1);
    reset = 1'b0;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_full", 32'(full), 32'd0);
`ifdef FIFO_LEVEL_EN
    check("rst_level", 32'(level), 32'd0);
`endif
    cyc(1, 16'h0777, 0);
    check("post_rst_dout", 32'(dout), 32'h0777);
    cyc(0, '0, 1);
    cyc(0, '0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
